// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB3 protocol monitor of the SRAM-APB subsystem.
package apb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mon_state_e;

    localparam int APB_MON_ERR_W = 6;

    localparam int ERR_MULTI_SEL = 0;
    localparam int ERR_NO_SETUP  = 1;
    localparam int ERR_NO_ACCESS = 2;
    localparam int ERR_UNSTABLE  = 3;
    localparam int ERR_TIMEOUT   = 4;
    localparam int ERR_SLVERR    = 5;

    // Index of the lowest set select bit; 0 when none are set.
    function automatic logic [3:0] lowest_sel(input logic [15:0] sel);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (sel[i-1]) begin
                idx = 4'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_protocol_monitor_if.sv
// APB3 bus bundle observed by the protocol monitor; master/slave views plus a passive monitor view.
interface apb_protocol_monitor_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic [NUM_SLV-1:0] PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDR_W-1:0]  PADDR;
    logic [DATA_W-1:0]  PWDATA;
    logic               PREADY;
    logic               PSLVERR;
    logic [DATA_W-1:0]  PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );

    modport monitor (
        input PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_mon_stats.sv
// Optional transfer statistics for the APB monitor; only present when APB_MON_STATS_EN is defined.
`ifdef APB_MON_STATS_EN
module apb_mon_stats #(
    parameter int WAIT_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              done,
    input  logic              write,
    input  logic              err,
    input  logic [WAIT_W-1:0] wait_cyc,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       err_cnt,
    output logic [WAIT_W-1:0] max_wait
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err_cnt  <= '0;
            max_wait <= '0;
        end else if (done) begin
            if (write && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (!write && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 32'd1;
            end
            if (wait_cyc > max_wait) begin
                max_wait <= wait_cyc;
            end
        end
    end

endmodule
`endif

// File: rtl/apb_protocol_monitor.sv
// Passive APB3 protocol monitor: sticky violation flags and a one-cycle record per completed transfer.
// Define APB_MON_STATS_EN to add the stat_* counter outputs.
module apb_protocol_monitor
    import apb_sram_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 256,
    localparam int SLV_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
    localparam int WAIT_W     = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    apb_protocol_monitor_if.monitor  bus,
    input  logic                     clr_i,
    output logic [APB_MON_ERR_W-1:0] err_status,
    output logic                     err_pulse,
    output logic                     txn_done,
    output logic                     txn_write,
    output logic [SLV_W-1:0]         txn_slv,
    output logic [ADDR_W-1:0]        txn_addr,
    output logic [DATA_W-1:0]        txn_data,
    output logic                     txn_err,
    output logic [WAIT_W-1:0]        txn_wait
`ifdef APB_MON_STATS_EN
    ,
    output logic [31:0]              stat_wr_cnt,
    output logic [31:0]              stat_rd_cnt,
    output logic [31:0]              stat_err_cnt,
    output logic [WAIT_W-1:0]        stat_max_wait
`endif
);

    apb_mon_state_e state;

    logic [NUM_SLV-1:0] lat_sel;
    logic [ADDR_W-1:0]  lat_addr;
    logic               lat_write;
    logic [DATA_W-1:0]  lat_wdata;
    logic [SLV_W-1:0]   lat_slv;
    logic [WAIT_W-1:0]  wait_cnt;

    logic                     sel_any;
    logic                     go_access;
    logic                     access_cyc;
    logic                     complete;
    logic                     start;
    logic                     unstable;
    logic [APB_MON_ERR_W-1:0] err_new;

    // The state register names the phase of the previous bus cycle, so the
    // first ACCESS cycle is observed while state is still SETUP.
    always_comb begin
        sel_any    = |bus.PSEL;
        go_access  = bus.PENABLE && (bus.PSEL == lat_sel);
        access_cyc = ((state == SETUP) && go_access) || ((state == ACCESS) && sel_any);
        complete   = access_cyc && bus.PREADY;
        start      = sel_any && !bus.PENABLE &&
                     ((state == IDLE) || (state == SETUP) || complete);
        unstable   = (bus.PADDR != lat_addr) || (bus.PWRITE != lat_write) ||
                     (bus.PSEL != lat_sel) || (lat_write && (bus.PWDATA != lat_wdata));
    end

    always_comb begin
        err_new = '0;
        err_new[ERR_MULTI_SEL] = $countones(bus.PSEL) > 1;
        case (state)
            IDLE: begin
                err_new[ERR_NO_SETUP] = bus.PENABLE;
            end
            SETUP: begin
                err_new[ERR_NO_ACCESS] = !go_access;
                err_new[ERR_UNSTABLE]  = unstable;
            end
            ACCESS: begin
                err_new[ERR_UNSTABLE]  = unstable;
            end
            default: begin
                err_new = '0;
            end
        endcase
        err_new[ERR_TIMEOUT] = access_cyc && !bus.PREADY &&
                               (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
        err_new[ERR_SLVERR]  = complete && bus.PSLVERR;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            err_status <= '0;
            err_pulse  <= 1'b0;
            txn_done   <= 1'b0;
            txn_write  <= 1'b0;
            txn_slv    <= '0;
            txn_addr   <= '0;
            txn_data   <= '0;
            txn_err    <= 1'b0;
            txn_wait   <= '0;
        end else begin
            err_status <= (clr_i ? '0 : err_status) | err_new;
            err_pulse  <= |err_new;
            txn_done   <= 1'b0;
            if (complete) begin
                txn_done  <= 1'b1;
                txn_write <= lat_write;
                txn_slv   <= lat_slv;
                txn_addr  <= lat_addr;
                txn_data  <= lat_write ? lat_wdata : bus.PRDATA;
                txn_err   <= bus.PSLVERR;
                txn_wait  <= wait_cnt;
                wait_cnt  <= '0;
                state     <= start ? SETUP : IDLE;
            end else if (access_cyc) begin
                state <= ACCESS;
                if (wait_cnt != WAIT_W'(TIMEOUT_CYC)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else if (start) begin
                state    <= SETUP;
                wait_cnt <= '0;
            end else begin
                state    <= IDLE;
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lat_sel   <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_slv   <= '0;
        end else if (start) begin
            lat_sel   <= bus.PSEL;
            lat_addr  <= bus.PADDR;
            lat_write <= bus.PWRITE;
            lat_wdata <= bus.PWDATA;
            lat_slv   <= SLV_W'(lowest_sel(16'(bus.PSEL)));
        end
    end

`ifdef APB_MON_STATS_EN
    apb_mon_stats #(
        .WAIT_W (WAIT_W)
    ) u_stats (
        .clk      (PCLK),
        .rst      (PRESET),
        .clr      (clr_i),
        .done     (txn_done),
        .write    (txn_write),
        .err      (txn_err),
        .wait_cyc (txn_wait),
        .wr_cnt   (stat_wr_cnt),
        .rd_cnt   (stat_rd_cnt),
        .err_cnt  (stat_err_cnt),
        .max_wait (stat_max_wait)
    );
`endif

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Self-checking bench for apb_protocol_monitor: vector table plus multi-cycle corner sequences.
module tb_apb_protocol_monitor;

    localparam int TMO = 8;

    logic        PCLK;
    logic        PRESET;
    logic        clr_i;
    logic [5:0]  err_status;
    logic        err_pulse;
    logic        txn_done;
    logic        txn_write;
    logic [1:0]  txn_slv;
    logic [31:0] txn_addr;
    logic [31:0] txn_data;
    logic        txn_err;
    logic [3:0]  txn_wait;

    apb_protocol_monitor_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

    apb_protocol_monitor #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_SLV     (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .bus        (bus),
        .clr_i      (clr_i),
        .err_status (err_status),
        .err_pulse  (err_pulse),
        .txn_done   (txn_done),
        .txn_write  (txn_write),
        .txn_slv    (txn_slv),
        .txn_addr   (txn_addr),
        .txn_data   (txn_data),
        .txn_err    (txn_err),
        .txn_wait   (txn_wait)
    );

    typedef struct {
        logic [3:0]  psel;
        int          slv;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
        logic [5:0]  exp_err;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        wr;
        int          slv;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          wt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial forever begin
        @(posedge PCLK);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp_v);
        end
    endtask

    // Scoreboard consumer: every txn_done must match the oldest expected record, on time.
    initial forever begin
        exp_t e;
        @(negedge PCLK);
        if (err_pulse) pulse_cnt = pulse_cnt + 1;
        if (txn_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_txn_done", 64'(txn_done), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("txn_write", 64'(txn_write), 64'(e.wr));
                chk("txn_addr", 64'(txn_addr), 64'(e.addr));
                chk("txn_data", 64'(txn_data), 64'(e.data));
                chk("txn_err", 64'(txn_err), 64'(e.err));
                chk("txn_wait", 64'(txn_wait), 64'(e.wt));
                if (e.slv >= 0) chk("txn_slv", 64'(txn_slv), 64'(e.slv));
            end
        end
    end

    task automatic bus_idle();
        bus.PSEL    = '0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(posedge PCLK); #1;
        clr_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_err_status"}, 64'(err_status), 64'(0));
        chk({tag, "_err_pulse"}, 64'(err_pulse), 64'(0));
        chk({tag, "_txn_done"}, 64'(txn_done), 64'(0));
        chk({tag, "_txn_write"}, 64'(txn_write), 64'(0));
        chk({tag, "_txn_slv"}, 64'(txn_slv), 64'(0));
        chk({tag, "_txn_addr"}, 64'(txn_addr), 64'(0));
        chk({tag, "_txn_data"}, 64'(txn_data), 64'(0));
        chk({tag, "_txn_err"}, 64'(txn_err), 64'(0));
        chk({tag, "_txn_wait"}, 64'(txn_wait), 64'(0));
    endtask

    // Called at posedge+1; drives one legal transfer and queues its expected record.
    task automatic apb_xfer(input logic [3:0] psel, input int slv, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input logic slverr,
                            input logic b2b, input logic glitch, input logic clr_done);
        exp_t e;
        bus.PSEL    = psel;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        for (int i = 0; i < waits; i++) begin
            bus.PREADY = 1'b0;
            bus.PADDR  = (glitch && i == 0) ? (addr ^ 32'h4) : addr;
            bus.PRDATA = ~rdata;
            @(posedge PCLK); #1;
        end
        bus.PADDR   = addr;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = slverr;
        bus.PRDATA  = rdata;
        clr_i       = clr_done;
        e.cyc  = cyc + 1;
        e.wr   = wr;
        e.slv  = slv;
        e.addr = addr;
        e.data = wr ? wdata : rdata;
        e.err  = slverr;
        e.wt   = (waits > TMO) ? TMO : waits;
        sb.push_back(e);
        @(posedge PCLK); #1;
        clr_i       = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        if (!b2b) begin
            bus.PSEL    = '0;
            bus.PENABLE = 1'b0;
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 0, 1'b1, 32'h10,   32'hA5A5A5A5, 32'hFFFF0000, 0, 1'b0, 6'h00};
        vecs[1] = '{4'b0100, 2, 1'b0, 32'h20,   32'h0,        32'h1234,     3, 1'b0, 6'h00};
        vecs[2] = '{4'b0010, 1, 1'b1, 32'h44,   32'hDEADBEEF, 32'h0BADBAD0, 1, 1'b0, 6'h00};
        vecs[3] = '{4'b1000, 3, 1'b0, 32'hFFFC, 32'h0,        32'hCAFEF00D, 0, 1'b1, 6'h20};
        vecs[4] = '{4'b0001, 0, 1'b0, 32'h8,    32'h0,        32'h55AA,     2, 1'b0, 6'h20};
        vecs[5] = '{4'b1000, 3, 1'b1, 32'h100,  32'h0BADF00D, 32'h12345678, 4, 1'b0, 6'h20};

        // Reset with a hostile bus: everything must read as zero.
        PRESET = 1'b1;
        clr_i  = 1'b0;
        bus.PSEL = 4'hF; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'hFFFFFFFF;
        bus.PWDATA = 32'hFFFFFFFF; bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hFFFFFFFF;
        repeat (3) @(posedge PCLK);
        #1;
        chk_zero("reset");
        PRESET = 1'b0;
        bus_idle();
        @(posedge PCLK); #1;
        chk("post_reset_err", 64'(err_status), 64'(0));

        for (int v = 0; v < 6; v++) begin
            apb_xfer(vecs[v].psel, vecs[v].slv, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                     vecs[v].rdata, vecs[v].waits, vecs[v].slverr, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_err_status", v), 64'(err_status), 64'(vecs[v].exp_err));
        end

        // Back-to-back: second SETUP right after the first completion.
        pulse_clr();
        apb_xfer(4'b0001, 0, 1'b1, 32'h200, 32'h11112222, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        apb_xfer(4'b0100, 2, 1'b0, 32'h204, 32'h0, 32'h33334444, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_err_status", 64'(err_status), 64'(0));

        // PENABLE with no preceding SETUP.
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b0;
        chk("no_setup_err_status", 64'(err_status), 64'(6'b000010));
        chk("no_setup_err_pulse", 64'(err_pulse), 64'(1));
        @(posedge PCLK); #1;
        chk("no_setup_pulse_drop", 64'(err_pulse), 64'(0));
        chk("no_setup_sticky", 64'(err_status), 64'(6'b000010));

        // Address change during a wait state.
        pulse_clr();
        apb_xfer(4'b0010, 1, 1'b0, 32'h80, 32'h0, 32'h9999, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("unstable_err_status", 64'(err_status), 64'(6'b001000));

        // Two selects at once.
        pulse_clr();
        apb_xfer(4'b0011, -1, 1'b1, 32'hC0, 32'h600DF00D, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("multi_sel_err_status", 64'(err_status), 64'(6'b000001));

        // Timeout: 10 wait states against an 8-cycle limit.
        pulse_clr();
        pulse_cnt = 0;
        apb_xfer(4'b0010, 1, 1'b0, 32'h90, 32'h0, 32'h77, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("timeout_err_status", 64'(err_status), 64'(6'b010000));
        chk("timeout_pulse_count", 64'(pulse_cnt), 64'(1));

        // clr_i on the same cycle as a PSLVERR completion: the set wins, the old bit clears.
        apb_xfer(4'b1000, 3, 1'b1, 32'hA0, 32'h11, 32'h0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_set_err_status", 64'(err_status), 64'(6'b100000));

        // Reset during ACCESS: transfer dropped, outputs cleared.
        bus.PSEL = 4'b0100; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h300;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1; bus.PREADY = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1; bus.PREADY = 1'b1; bus.PRDATA = 32'hABCD;
        @(posedge PCLK); #1;
        chk_zero("reset_mid_access");
        PRESET = 1'b0;
        bus_idle();
        repeat (3) @(posedge PCLK);
        #1;
        chk("post_reset_mid_err", 64'(err_status), 64'(0));
        chk("post_reset_mid_done", 64'(txn_done), 64'(0));

        repeat (2) @(posedge PCLK);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
